nibble_serial_adder_ctrl: RTL
=============================

# nibble_serial_adder_ctrl

Multi-cycle wide adder that sequences one 4-bit carry-skip adder slice across a WIDTH-bit operand pair, one nibble per clock. Operands enter through a valid/ready handshake, and the result leaves through a second valid/ready handshake. The block is the area-optimised alternative to a full-width parallel adder in datapaths where throughput of one add per WIDTH/4+2 cycles is sufficient.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 4, minimum 8.
- N (derived, not overridable), WIDTH/4, number of nibble steps.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to nibble 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  A+B+cin modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow (carry into MSB XOR cout).
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, cin into operand registers, clear the nibble index to 0 and sum to 0, and go to RUN.
- RUN: each cycle, the slice adds a_reg[4i+3:4i], b_reg[4i+3:4i], and carry_reg.
  - Write the nibble into sum[4i+3:4i] and register the slice carry-out into carry_reg.
  - Increment i.
  - On the step where i==N-1, also capture ovf = carry-into-bit-3-of-slice XOR slice carry-out, drive cout from the final carry, and go to DONE.
- Slice carry-skip rule: if all four P=a^b bits of the nibble are 1, the slice carry-out equals the slice carry-in. Otherwise it is the rippled carry. Both paths must give identical results.
- DONE: out_valid=1. sum, cout and ovf are held stable until out_valid&&out_ready, then the block goes to IDLE.
- in_ready=0 in RUN and DONE. in_valid in those states is ignored, and operand registers do not change.
- Operand inputs are sampled only on the accept edge. Changes on a, b or cin afterwards have no effect.
- Nibble index is log2(N) bits wide and wraps only via reset or a new accept. It never exceeds N-1.

## Timing
- Reset (rst_n=0 at a rising edge) sets:
  - state=IDLE
  - in_ready=1, out_valid=0, busy=0
  - sum=0, cout=0, ovf=0
  - index=0, carry_reg=0
- Reset mid-operation aborts with no partial result ever presented. Reset takes priority over all handshakes.
- Latency: accept at edge E0. Nibble steps occur at edges E1..EN. out_valid is high from EN, i.e. N cycles after accept (8 for WIDTH=32).
- Result handshake at edge Ek means out_valid=0 and in_ready=1 after Ek. The next accept can occur at Ek+1.
- Maximum throughput is one result per N+2 cycles, with in_valid and out_ready held high.
- out_ready low holds DONE indefinitely. Outputs must not glitch or change.
- out_ready high while not in DONE has no effect.

## Test plan
- WIDTH=32, a=0xFFFFFFFF, b=0x00000001, cin=0 -> after 8 cycles out_valid=1, sum=0x00000000, cout=1, ovf=0.
- a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1. Also a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
- Skip path: a=0x0F0F0F0F, b=0xF0F0F0F0, cin=1 -> sum=0x00000000, cout=1. With cin=0 -> sum=0xFFFFFFFF, cout=0.
- Backpressure: complete a=0x12345678 + b=0x11111111, hold out_ready=0 for 5 cycles while toggling in_valid and a/b.
  - Required: sum=0x23456789 stays stable, in_ready=0, and no new accept.
  - Raise out_ready: handshake occurs, then in_ready=1 on the next cycle.
- Reset: pull rst_n low at the 3rd nibble step of any operation -> all outputs at reset values the next cycle. A subsequent add of 0x00000005+0x00000003 yields 0x00000008 with correct 8-cycle latency.
- Streaming: in_valid=1 and out_ready=1 continuously with 4 random operand pairs -> results match the golden model, and accepts are spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder: one 4-bit carry-skip slice stepped across the operands,
// one nibble per clock, with valid/ready handshakes on both the operand and result sides.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic [IW-1:0]    idx_q;

  logic [3:0] a_nib [N];
  logic [3:0] b_nib [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_nib
      assign a_nib[gi] = a_q[4*gi +: 4];
      assign b_nib[gi] = b_q[4*gi +: 4];
    end
  endgenerate

  logic [3:0] slice_a, slice_b, slice_p, slice_g, slice_sum;
  logic       c1, c2, c3, c4, slice_cout;
  logic       last_step;

  always_comb begin
    slice_a    = a_nib[idx_q];
    slice_b    = b_nib[idx_q];
    slice_p    = slice_a ^ slice_b;
    slice_g    = slice_a & slice_b;
    c1         = slice_g[0] | (slice_p[0] & carry_q);
    c2         = slice_g[1] | (slice_p[1] & c1);
    c3         = slice_g[2] | (slice_p[2] & c2);
    c4         = slice_g[3] | (slice_p[3] & c3);
    slice_sum  = slice_p ^ {c3, c2, c1, carry_q};
    // All-propagate nibble: the carry-in skips straight to the carry-out.
    slice_cout = (&slice_p) ? carry_q : c4;
    last_step  = (idx_q == LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[4*idx_q +: 4] <= slice_sum;
          carry_q             <= slice_cout;
          if (last_step) begin
            cout_q <= slice_cout;
            ovf_q  <= c3 ^ slice_cout;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
